// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared fetch-stage types and constants (package riscv_pipe_pkg).
package riscv_pipe_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} fetch_state_t;
    typedef struct packed {
        logic [31:0]         instr;
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] pc_plus4;
        logic                valid;
    } if_id_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: imem bus, hazard controls and IF/ID outputs of the fetch stage.
// FETCH_MISALIGN_EN adds the misalign_d signal.
interface instr_fetch_unit_if
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            stall_f;
    logic            stall_d;
    logic            flush_d;
    logic            pc_src_e;
    logic [XLEN-1:0] pc_target_e;
    logic            halt_i;
    logic [31:0]     instr_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4_d;
    logic            valid_d;
    logic            halted_o;
`ifdef FETCH_MISALIGN_EN
    logic            misalign_d;
    modport master (
        output imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, halted_o, misalign_d,
        input  imem_rdata, stall_f, stall_d, flush_d, pc_src_e, pc_target_e, halt_i
    );
    modport slave (
        input  imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, halted_o, misalign_d,
        output imem_rdata, stall_f, stall_d, flush_d, pc_src_e, pc_target_e, halt_i
    );
`else
    modport master (
        output imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, halted_o,
        input  imem_rdata, stall_f, stall_d, flush_d, pc_src_e, pc_target_e, halt_i
    );
    modport slave (
        input  imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, halted_o,
        output imem_rdata, stall_f, stall_d, flush_d, pc_src_e, pc_target_e, halt_i
    );
`endif
endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// pc_reg: program counter with redirect/hold/increment next-PC selection.
module pc_reg
    import riscv_pipe_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_hold,
    output logic [XLEN-1:0] o_pc
);
    logic [XLEN-1:0] r_pc;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pc <= RESET_PC;
        else if (i_load) r_pc <= i_target;
        else if (!i_hold) r_pc <= r_pc + XLEN'(4);
    end
    assign o_pc = r_pc;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RISC-V fetch stage with BOOT/RUN/HALT control and IF/ID register.
// FETCH_MISALIGN_EN enables misaligned-PC tagging; otherwise redirect targets are word-aligned.
module instr_fetch_unit
    import riscv_pipe_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    instr_fetch_unit_if.master         bus
);
    localparam logic [1:0] ST_BOOT = BOOT;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_HALT = HALT;
    localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

    logic [1:0]      r_state;
    if_id_t          r_ifid;
    logic            w_run;
    logic            w_bubble;
    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_target;
    logic [31:0]     w_instr;

    assign w_run      = r_state == ST_RUN;
    assign w_bubble   = bus.flush_d || !w_run || bus.pc_src_e;
    assign w_pc_plus4 = w_pc + XLEN'(4);

`ifdef FETCH_MISALIGN_EN
    logic w_misalign;
    logic r_misalign;
    assign w_misalign = w_pc[1:0] != 2'b00;
    assign w_target   = bus.pc_target_e;
    assign w_instr    = w_misalign ? NOP_INSTR : bus.imem_rdata;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_misalign <= 1'b0;
        else if (w_bubble) r_misalign <= 1'b0;
        else if (!bus.stall_d) r_misalign <= w_misalign;
    end
    assign bus.misalign_d = r_misalign;
`else
    assign w_target = bus.pc_target_e & ~XLEN'(3);
    assign w_instr  = bus.imem_rdata;
`endif

    pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (bus.pc_src_e),
        .i_target (w_target),
        .i_hold   (!w_run || bus.stall_f || bus.halt_i),
        .o_pc     (w_pc)
    );

    // a redirect while running cancels halt entry; BOOT and invalid codes fall into RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_BOOT;
        else r_state <= w_run ? ((bus.halt_i && !bus.pc_src_e) ? ST_HALT : ST_RUN)
                              : (r_state == ST_HALT && bus.halt_i) ? ST_HALT : ST_RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_ifid <= BUBBLE;
        else if (w_bubble) r_ifid <= BUBBLE;
        else if (!bus.stall_d) r_ifid <= '{instr: w_instr, pc: w_pc, pc_plus4: w_pc_plus4, valid: 1'b1};
    end

    assign bus.imem_addr  = w_pc;
    assign bus.instr_d    = r_ifid.instr;
    assign bus.pc_d       = r_ifid.pc;
    assign bus.pc_plus4_d = r_ifid.pc_plus4;
    assign bus.valid_d    = r_ifid.valid;
    assign bus.halted_o   = r_state == ST_HALT;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks of instr_fetch_unit against a behavioural model.
module tb_instr_fetch_unit;
    import riscv_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.XLEN(32)) bus ();
    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [256];
    assign bus.imem_rdata = rst ? mem[bus.imem_addr[9:2]] : 32'h0;

    logic [31:0] m_pc, m_instr, m_pcd, m_p4;
    logic        m_valid, m_mis, m_boot, m_halt;
    int checks = 0;
    int errors = 0;

    task automatic drive(input logic sf, input logic sd, input logic fl, input logic rd,
                         input logic [31:0] tg, input logic h);
        bus.stall_f = sf; bus.stall_d = sd; bus.flush_d = fl;
        bus.pc_src_e = rd; bus.pc_target_e = tg; bus.halt_i = h;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP_INSTR; m_pcd = 32'h0; m_p4 = 32'h0;
        m_valid = 1'b0; m_mis = 1'b0; m_boot = 1'b1; m_halt = 1'b0;
    endtask

    // one clock edge; model follows the stage rules in plain arithmetic
    task automatic step();
        logic [31:0] npc, ninstr, npcd, np4, tgt;
        logic nvalid, nmis, nhalt, fetching, mis;
        fetching = !m_boot && !m_halt;
`ifdef FETCH_MISALIGN_EN
        tgt = bus.pc_target_e;
        mis = m_pc[1:0] != 2'b00;
`else
        tgt = {bus.pc_target_e[31:2], 2'b00};
        mis = 1'b0;
`endif
        npc = bus.pc_src_e ? tgt : (!fetching || bus.stall_f || bus.halt_i) ? m_pc : m_pc + 32'd4;
        ninstr = m_instr; npcd = m_pcd; np4 = m_p4; nvalid = m_valid; nmis = m_mis;
        if (bus.flush_d || !fetching || bus.pc_src_e) begin
            ninstr = NOP_INSTR; npcd = 32'h0; np4 = 32'h0; nvalid = 1'b0; nmis = 1'b0;
        end else if (!bus.stall_d) begin
            ninstr = mis ? NOP_INSTR : mem[m_pc[9:2]];
            npcd = m_pc; np4 = m_pc + 32'd4; nvalid = 1'b1; nmis = mis;
        end
        nhalt = fetching ? (bus.halt_i && !bus.pc_src_e) : (m_halt && bus.halt_i);
        @(posedge clk);
        #1;
        m_pc = npc; m_instr = ninstr; m_pcd = npcd; m_p4 = np4;
        m_valid = nvalid; m_mis = nmis; m_halt = nhalt; m_boot = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0062E233;
        mem[1] = 32'h00B62423;
        drive(0, 0, 0, 0, 32'h0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.instr_d, bus.pc_d, bus.pc_plus4_d, bus.valid_d, bus.halted_o, bus.imem_addr} !==
            {NOP_INSTR, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state instr=%h pc_d=%h p4=%h valid=%b halted=%b addr=%h",
                     bus.instr_d, bus.pc_d, bus.pc_plus4_d, bus.valid_d, bus.halted_o, bus.imem_addr);
        end
        @(negedge clk) rst = 1'b1;
        step();
        checks++;
        if (bus.valid_d !== 1'b0 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL boot_bubble valid=%b addr=%h want valid=0 addr=0", bus.valid_d, bus.imem_addr);
        end
        step();
        checks++;
        if ({bus.instr_d, bus.pc_d, bus.valid_d} !== {32'h0062E233, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL first_fetch instr=%h pc_d=%h valid=%b want 0062e233/0/1",
                     bus.instr_d, bus.pc_d, bus.valid_d);
        end
        step();
        checks++;
        if ({bus.instr_d, bus.pc_d, bus.pc_plus4_d} !== {32'h00B62423, 32'h4, 32'h8}) begin
            errors++;
            $display("FAIL second_fetch instr=%h pc_d=%h p4=%h want 00b62423/4/8",
                     bus.instr_d, bus.pc_d, bus.pc_plus4_d);
        end
    endtask

    task automatic test_stall();
        drive(1, 1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus.imem_addr, bus.instr_d, bus.pc_d, bus.valid_d} !== {32'h8, 32'h00B62423, 32'h4, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d addr=%h instr=%h pc_d=%h valid=%b want 8/00b62423/4/1",
                         i, bus.imem_addr, bus.instr_d, bus.pc_d, bus.valid_d);
            end
        end
        drive(0, 0, 0, 0, 32'h0, 0);
        step();
        checks++;
        if ({bus.instr_d, bus.pc_d, bus.valid_d} !== {mem[2], 32'h8, 1'b1}) begin
            errors++;
            $display("FAIL stall_release instr=%h pc_d=%h valid=%b want %h/8/1",
                     bus.instr_d, bus.pc_d, bus.valid_d, mem[2]);
        end
    endtask

    task automatic test_redirect();
        drive(1, 1, 0, 1, 32'h40, 0);
        step();
        checks++;
        if ({bus.imem_addr, bus.instr_d, bus.valid_d} !== {32'h40, NOP_INSTR, 1'b0}) begin
            errors++;
            $display("FAIL redirect_bubble addr=%h instr=%h valid=%b want 40/00000013/0",
                     bus.imem_addr, bus.instr_d, bus.valid_d);
        end
        drive(0, 0, 0, 0, 32'h0, 0);
        step();
        checks++;
        if ({bus.instr_d, bus.pc_d, bus.valid_d} !== {mem[16], 32'h40, 1'b1}) begin
            errors++;
            $display("FAIL redirect_target instr=%h pc_d=%h valid=%b want %h/40/1",
                     bus.instr_d, bus.pc_d, bus.valid_d, mem[16]);
        end
    endtask

    task automatic test_halt();
        drive(0, 0, 0, 1, 32'h10, 0);
        step();
        drive(0, 0, 0, 0, 32'h0, 1);
        step();
        checks++;
        if ({bus.halted_o, bus.pc_d, bus.valid_d, bus.imem_addr} !== {1'b1, 32'h10, 1'b1, 32'h10}) begin
            errors++;
            $display("FAIL halt_enter halted=%b pc_d=%h valid=%b addr=%h want 1/10/1/10",
                     bus.halted_o, bus.pc_d, bus.valid_d, bus.imem_addr);
        end
        step();
        checks++;
        if ({bus.halted_o, bus.valid_d, bus.imem_addr} !== {1'b1, 1'b0, 32'h10}) begin
            errors++;
            $display("FAIL halt_bubble halted=%b valid=%b addr=%h want 1/0/10",
                     bus.halted_o, bus.valid_d, bus.imem_addr);
        end
        drive(0, 0, 0, 0, 32'h0, 0);
        step();
        checks++;
        if ({bus.halted_o, bus.valid_d, bus.imem_addr} !== {1'b0, 1'b0, 32'h10}) begin
            errors++;
            $display("FAIL halt_exit halted=%b valid=%b addr=%h want 0/0/10",
                     bus.halted_o, bus.valid_d, bus.imem_addr);
        end
        step();
        checks++;
        if ({bus.pc_d, bus.valid_d, bus.imem_addr} !== {32'h10, 1'b1, 32'h14}) begin
            errors++;
            $display("FAIL halt_resume pc_d=%h valid=%b addr=%h want 10/1/14",
                     bus.pc_d, bus.valid_d, bus.imem_addr);
        end
    endtask

    task automatic test_wrap();
        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        step();
        drive(0, 0, 0, 0, 32'h0, 0);
        step();
        checks++;
        if ({bus.imem_addr, bus.pc_d, bus.pc_plus4_d, bus.instr_d} !== {32'h0, 32'hFFFF_FFFC, 32'h0, mem[255]}) begin
            errors++;
            $display("FAIL pc_wrap addr=%h pc_d=%h p4=%h instr=%h want 0/fffffffc/0/%h",
                     bus.imem_addr, bus.pc_d, bus.pc_plus4_d, bus.instr_d, mem[255]);
        end
    endtask

`ifdef FETCH_MISALIGN_EN
    task automatic test_misalign();
        drive(0, 0, 0, 1, 32'h22, 0);
        step();
        drive(0, 0, 0, 0, 32'h0, 0);
        step();
        checks++;
        if ({bus.misalign_d, bus.pc_d, bus.instr_d, bus.valid_d} !== {1'b1, 32'h22, NOP_INSTR, 1'b1}) begin
            errors++;
            $display("FAIL misalign_tag mis=%b pc_d=%h instr=%h valid=%b want 1/22/00000013/1",
                     bus.misalign_d, bus.pc_d, bus.instr_d, bus.valid_d);
        end
        drive(0, 0, 1, 0, 32'h0, 0);
        step();
        checks++;
        if ({bus.misalign_d, bus.valid_d} !== 2'b00) begin
            errors++;
            $display("FAIL misalign_flush mis=%b valid=%b want 0/0", bus.misalign_d, bus.valid_d);
        end
        drive(0, 0, 0, 0, 32'h0, 0);
    endtask
`endif

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
                  $urandom_range(7) == 0, $urandom, $urandom_range(4) == 0);
            step();
            checks++;
            if ({bus.imem_addr, bus.instr_d, bus.pc_d, bus.pc_plus4_d, bus.valid_d, bus.halted_o} !==
                {m_pc, m_instr, m_pcd, m_p4, m_valid, m_halt}) begin
                errors++;
                $display("FAIL random cyc=%0d got addr=%h instr=%h pc_d=%h p4=%h v=%b h=%b want %h %h %h %h %b %b",
                         i, bus.imem_addr, bus.instr_d, bus.pc_d, bus.pc_plus4_d, bus.valid_d, bus.halted_o,
                         m_pc, m_instr, m_pcd, m_p4, m_valid, m_halt);
            end
`ifdef FETCH_MISALIGN_EN
            checks++;
            if (bus.misalign_d !== m_mis) begin
                errors++;
                $display("FAIL random_misalign cyc=%0d got %b want %b", i, bus.misalign_d, m_mis);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        test_random(20);
        #2 rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({bus.imem_addr, bus.instr_d, bus.pc_d, bus.pc_plus4_d, bus.valid_d, bus.halted_o} !==
            {32'h0, NOP_INSTR, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async addr=%h instr=%h pc_d=%h p4=%h valid=%b halted=%b",
                     bus.imem_addr, bus.instr_d, bus.pc_d, bus.pc_plus4_d, bus.valid_d, bus.halted_o);
        end
        @(negedge clk) rst = 1'b1;
        test_random(60);
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
`ifdef FETCH_MISALIGN_EN
        test_misalign();
`endif
        test_random(400);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the 5-stage RISC-V pipeline.
- Owns the PC and drives the address port of the instruction memory, which returns a word combinationally: rdata = mem[addr[31:2]], and 0 while reset is asserted.
- Registers the fetched word into the IF/ID pipeline register.
- Honours stall, flush, halt and branch/jump redirect from the hazard unit and execute stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address/data width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- imem_addr  output  XLEN  address to instruction memory; equals pc_f.
- imem_rdata  input  32  instruction word returned combinationally by memory.
- stall_f  input  1  hold pc_f (load-use hazard).
- stall_d  input  1  hold IF/ID register contents.
- flush_d  input  1  replace IF/ID contents with a bubble.
- pc_src_e  input  1  redirect request from execute stage.
- pc_target_e  input  XLEN  redirect target.
- halt_i  input  1  freeze fetch and issue bubbles while high.
- instr_d  output  32  IF/ID instruction.
- pc_d  output  XLEN  IF/ID PC.
- pc_plus4_d  output  XLEN  IF/ID PC+4.
- valid_d  output  1  IF/ID holds a real instruction.
- halted_o  output  1  FSM is in HALT.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_f=RESET_PC, state=BOOT.
  - instr_d=NOP_INSTR (32'h0000_0013), pc_d=0, pc_plus4_d=0, valid_d=0, halted_o=0.
- FSM states:
  - BOOT: entered on reset. Lasts exactly one clk edge after rst deasserts. pc_f holds and IF/ID loads a bubble, so memory leaves its reset-zero output before first capture. Always goes to RUN.
  - RUN: normal fetch. Goes to HALT when halt_i=1 at an edge and there is no redirect; the IF/ID register still captures that cycle's word.
  - HALT: pc_f frozen, IF/ID loads a bubble each edge, halted_o=1. Returns to RUN on the first edge with halt_i=0. A redirect in HALT updates pc_f and the FSM stays in HALT.
- pc_f next value, in priority order:
  1. pc_src_e=1 -> pc_target_e. Overrides stall_f and halt.
  2. state!=RUN, or stall_f=1, or halt_i=1 -> hold.
  3. Otherwise pc_f+4.
  - Addition is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- IF/ID next value, in priority order:
  1. flush_d=1, or state!=RUN, or pc_src_e=1 -> bubble (NOP_INSTR, valid_d=0, pc_d/pc_plus4_d=0). Flush beats stall_d.
  2. stall_d=1 -> hold.
  3. Otherwise capture imem_rdata, pc_f, pc_f+4, valid_d=1.
- Latency:
  - An instruction at address A appears on instr_d one edge after pc_f=A.
  - Redirect penalty: the edge with pc_src_e=1 loads a bubble; the target instruction appears one edge later.
- stall_f=1 with stall_d=0 is legal: IF/ID re-captures the same word.
- Reset mid-operation discards everything immediately; no partial state is preserved.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- When defined:
  - Adds output misalign_d (1 bit).
  - pc_f[1:0]!=0 in RUN -> IF/ID captures NOP_INSTR with valid_d=1, misalign_d=1, pc_d=pc_f. Trap logic downstream uses this.
  - misalign_d is cleared by reset, flush and bubbles, and held by stall_d.
- When undefined:
  - No port.
  - pc_target_e[1:0] is ignored and forced to 0 when loaded into pc_f.

Decomposition:
- Package riscv_pipe_pkg holds:
  - NOP_INSTR.
  - XLEN default.
  - FSM enum fetch_state_t {BOOT, RUN, HALT}.
  - IF/ID bundle struct if_id_t {instr, pc, pc_plus4, valid}.
- One sub-module, pc_reg: the PC register with next-PC mux and async reset. The IF/ID register and FSM stay in the top.

Test Plan:
- Reset, then release with mem[0]=32'h0062E233 and mem[1]=32'h00B62423 -> cycle 1 is a bubble (valid_d=0). Then instr_d=0062E233 with pc_d=0, then 00B62423 with pc_d=4 and pc_plus4_d=8.
- stall_f=stall_d=1 for 3 cycles at pc_f=8 -> imem_addr stays 8 and IF/ID is unchanged. After release, pc_d=8 on the next edge.
- pc_src_e=1, pc_target_e=32'h40, with stall_f=1 and stall_d=1 -> pc_f=32'h40 and a bubble loads. The next edge gives pc_d=32'h40 and valid_d=1.
- halt_i high for 2 cycles at pc_f=32'h10 -> halted_o=1 and bubbles are issued. After deassert, the fetch resumes at 32'h10 with no skipped address.
- pc_f=32'hFFFF_FFFC -> next pc_f=0 and pc_plus4_d=0.
- FETCH_MISALIGN_EN defined, redirect to 32'h22 -> misalign_d=1, pc_d=32'h22, instr_d=NOP_INSTR. A following flush_d clears it.
